universal_shift_reg: RTL and testbench

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

---
 rtl/universal_shift_reg.sv | 83 ++++++++
 tb/tb_universal_shift_reg.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - universal shift register: hold, shift right/left, parallel load
// Shift count saturates at WIDTH; done mirrors the saturated count as a flop.
module universal_shift_reg #(
  parameter int WIDTH    = 8,
  parameter bit CIRCULAR = 1'b0
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic                       sin_r,
  input  logic                       sin_l,
  input  logic [WIDTH-1:0]           pdata,
  output logic [WIDTH-1:0]           q,
  output logic                       sout_r,
  output logic                       sout_l,
  output logic [$clog2(WIDTH+1)-1:0] cnt,
  output logic                       done
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             fill_r, fill_l;
  logic             shift_acc;
  logic [CW-1:0]    cnt_inc;

  // Rotate mode recirculates the outgoing bit; serial inputs are then unused.
  assign fill_r = CIRCULAR ? q_q[0]       : sin_r;
  assign fill_l = CIRCULAR ? q_q[WIDTH-1] : sin_l;

  assign shift_acc = en && ((mode == MODE_RIGHT) || (mode == MODE_LEFT));
  assign cnt_inc   = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (en) begin
      case (mode)
        MODE_RIGHT: q_d = {fill_r, q_q[WIDTH-1:1]};
        MODE_LEFT:  q_d = {q_q[WIDTH-2:0], fill_l};
        MODE_LOAD:  q_d = pdata;
        MODE_HOLD:  q_d = q_q;
        default:    q_d = q_q;
      endcase
    end
    if (shift_acc) begin
      cnt_d  = cnt_inc;
      done_d = (cnt_inc == CNT_FULL);
    end else if (en && (mode == MODE_LOAD)) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q      = q_q;
  assign cnt    = cnt_q;
  assign done   = done_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - directed vector bench for universal_shift_reg
module tb_universal_shift_reg;

  logic       clk = 1'b0;
  logic       clr;
  logic       en;
  logic [1:0] mode;
  logic       sin_r;
  logic       sin_l;
  logic [7:0] pdata8;
  logic [1:0] pdata2;

  logic [7:0] q8, q8r;
  logic [1:0] q2;
  logic       sr8, sl8, sr8r, sl8r, sr2, sl2;
  logic [3:0] cnt8, cnt8r;
  logic [1:0] cnt2;
  logic       done8, done8r, done2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(8), .CIRCULAR(1'b0)) u8 (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .pdata(pdata8), .q(q8), .sout_r(sr8), .sout_l(sl8), .cnt(cnt8), .done(done8));

  universal_shift_reg #(.WIDTH(8), .CIRCULAR(1'b1)) u8r (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .pdata(pdata8), .q(q8r), .sout_r(sr8r), .sout_l(sl8r), .cnt(cnt8r), .done(done8r));

  universal_shift_reg #(.WIDTH(2), .CIRCULAR(1'b0)) u2 (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .pdata(pdata2), .q(q2), .sout_r(sr2), .sout_l(sl2), .cnt(cnt2), .done(done2));

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic       sin_r;
    logic       sin_l;
    logic [7:0] pdata;
    logic [7:0] exp_q;
    logic [3:0] exp_cnt;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic e, input logic [1:0] m, input logic sr, input logic sl,
                              input logic [7:0] pd, input logic [7:0] eq, input logic [3:0] ec,
                              input logic ed);
    vec_t v;
    v.en = e; v.mode = m; v.sin_r = sr; v.sin_l = sl; v.pdata = pd;
    v.exp_q = eq; v.exp_cnt = ec; v.exp_done = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic e, input logic [1:0] m, input logic sr, input logic sl,
                       input logic [7:0] pd8, input logic [1:0] pd2);
    @(negedge clk);
    en = e; mode = m; sin_r = sr; sin_l = sl; pdata8 = pd8; pdata2 = pd2;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; mode = 2'b00; sin_r = 1'b0; sin_l = 1'b0;
    pdata8 = 8'h00; pdata2 = 2'b00;
    #1;
    check("reset_q", 64'(q8), 64'h0);
    check("reset_cnt", 64'(cnt8), 64'h0);
    check("reset_done", 64'(done8), 64'h0);
    check("reset_q_w2", 64'(q2), 64'h0);
    #20;
    clr = 1'b0;

    // Load A5, 8 right shifts with zero fill.
    vecs.push_back(mk(1, 2'b11, 1, 1, 8'hA5, 8'hA5, 0, 0));
    vecs.push_back(mk(1, 2'b01, 0, 1, 8'hFF, 8'h52, 1, 0));
    vecs.push_back(mk(1, 2'b01, 0, 1, 8'hFF, 8'h29, 2, 0));
    vecs.push_back(mk(1, 2'b01, 0, 0, 8'h00, 8'h14, 3, 0));
    vecs.push_back(mk(1, 2'b01, 0, 0, 8'h00, 8'h0A, 4, 0));
    vecs.push_back(mk(0, 2'b01, 1, 1, 8'h00, 8'h0A, 4, 0));
    vecs.push_back(mk(1, 2'b00, 1, 1, 8'hFF, 8'h0A, 4, 0));
    vecs.push_back(mk(1, 2'b01, 0, 0, 8'h00, 8'h05, 5, 0));
    vecs.push_back(mk(1, 2'b01, 0, 0, 8'h00, 8'h02, 6, 0));
    vecs.push_back(mk(1, 2'b01, 0, 0, 8'h00, 8'h01, 7, 0));
    vecs.push_back(mk(1, 2'b01, 0, 0, 8'h00, 8'h00, 8, 1));
    // Saturation: two more shifts, then three disabled cycles, then reload.
    vecs.push_back(mk(1, 2'b01, 1, 0, 8'h00, 8'h80, 8, 1));
    vecs.push_back(mk(1, 2'b10, 0, 1, 8'h00, 8'h01, 8, 1));
    vecs.push_back(mk(0, 2'b11, 1, 1, 8'hFF, 8'h01, 8, 1));
    vecs.push_back(mk(0, 2'b01, 1, 1, 8'hFF, 8'h01, 8, 1));
    vecs.push_back(mk(0, 2'b10, 1, 1, 8'hFF, 8'h01, 8, 1));
    vecs.push_back(mk(1, 2'b11, 0, 0, 8'h3C, 8'h3C, 0, 0));
    // Load 01, 3 left shifts with one fill.
    vecs.push_back(mk(1, 2'b11, 0, 0, 8'h01, 8'h01, 0, 0));
    vecs.push_back(mk(1, 2'b10, 1, 1, 8'hF0, 8'h03, 1, 0));
    vecs.push_back(mk(1, 2'b10, 0, 1, 8'hF0, 8'h07, 2, 0));
    vecs.push_back(mk(1, 2'b10, 1, 1, 8'hF0, 8'h0F, 3, 0));
    // Direction change keeps counting.
    vecs.push_back(mk(1, 2'b01, 1, 0, 8'h00, 8'h87, 4, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].mode, vecs[i].sin_r, vecs[i].sin_l, vecs[i].pdata, 2'b00);
      check($sformatf("vec%0d_q", i), 64'(q8), 64'(vecs[i].exp_q));
      check($sformatf("vec%0d_cnt", i), 64'(cnt8), 64'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_done", i), 64'(done8), 64'(vecs[i].exp_done));
      check($sformatf("vec%0d_sout_r", i), 64'(sr8), 64'(vecs[i].exp_q[0]));
      check($sformatf("vec%0d_sout_l", i), 64'(sl8), 64'(vecs[i].exp_q[7]));
    end

    // Rotate right on the circular instance; serial input held opposite to q[0].
    drive(1, 2'b11, 0, 0, 8'h81, 2'b00);
    check("rot_load_q", 64'(q8r), 64'h81);
    drive(1, 2'b01, 0, 0, 8'h00, 2'b00);
    check("rot_first_q", 64'(q8r), 64'hC0);
    check("rot_first_cnt", 64'(cnt8r), 64'h1);
    for (int i = 0; i < 7; i++) drive(1, 2'b01, 0, 0, 8'h00, 2'b00);
    check("rot_full_q", 64'(q8r), 64'h81);
    check("rot_full_cnt", 64'(cnt8r), 64'h8);
    check("rot_full_done", 64'(done8r), 64'h1);
    drive(1, 2'b10, 0, 0, 8'h00, 2'b00);
    check("rot_left_q", 64'(q8r), 64'h03);
    check("rot_left_cnt", 64'(cnt8r), 64'h8);

    // Asynchronous clear between edges.
    drive(1, 2'b11, 1, 1, 8'hFF, 2'b00);
    for (int i = 0; i < 4; i++) drive(1, 2'b01, 1, 1, 8'h00, 2'b00);
    check("pre_clr_cnt", 64'(cnt8), 64'h4);
    check("pre_clr_q", 64'(q8), 64'hFF);
    @(negedge clk);
    en = 1'b1; mode = 2'b01; sin_r = 1'b1;
    #1 clr = 1'b1;
    #1;
    check("async_clr_q", 64'(q8), 64'h0);
    check("async_clr_cnt", 64'(cnt8), 64'h0);
    check("async_clr_done", 64'(done8), 64'h0);
    #1 clr = 1'b0;
    @(posedge clk);
    #1;
    check("post_clr_q", 64'(q8), 64'h80);
    check("post_clr_cnt", 64'(cnt8), 64'h1);

    // Clear held across an edge ignores the requested load.
    @(negedge clk);
    clr = 1'b1; mode = 2'b11; pdata8 = 8'h5A;
    @(posedge clk);
    #1;
    check("clr_held_q", 64'(q8), 64'h0);
    @(negedge clk);
    clr = 1'b0;

    // Minimum width instance.
    drive(1, 2'b11, 0, 0, 8'h00, 2'b10);
    check("w2_load_q", 64'(q2), 64'h2);
    check("w2_load_sout_l", 64'(sl2), 64'h1);
    drive(1, 2'b10, 1, 0, 8'h00, 2'b11);
    check("w2_shift1_q", 64'(q2), 64'h0);
    check("w2_shift1_cnt", 64'(cnt2), 64'h1);
    check("w2_shift1_done", 64'(done2), 64'h0);
    drive(1, 2'b10, 1, 0, 8'h00, 2'b11);
    check("w2_final_q", 64'(q2), 64'h0);
    check("w2_final_cnt", 64'(cnt2), 64'h2);
    check("w2_final_done", 64'(done2), 64'h1);
    drive(1, 2'b01, 1, 0, 8'h00, 2'b11);
    check("w2_sat_q", 64'(q2), 64'h2);
    check("w2_sat_cnt", 64'(cnt2), 64'h2);
    check("w2_sat_sout_r", 64'(sr2), 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
